// File: rtl/uart_line_receiver_pkg.sv
// Shared UART definitions: receiver state encodings and bit-timing derivation.
package uart_line_receiver_pkg;

    localparam int unsigned DATA_BITS = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Clock cycles spent on one serial bit (integer truncation).
    function automatic int unsigned cycles_per_bit(input int unsigned clock_frequency,
                                                   input int unsigned baud_rate);
        return clock_frequency / baud_rate;
    endfunction

    // Offset from the start edge to the middle of the start bit.
    function automatic int unsigned half_bit(input int unsigned clock_frequency,
                                             input int unsigned baud_rate);
        return cycles_per_bit(clock_frequency, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: power-of-two depth, head byte presented combinationally.
module uart_rx_fifo
    import uart_line_receiver_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push,
    input  logic [DATA_BITS-1:0]          push_data,
    input  logic                          pop,
    output logic [DATA_BITS-1:0]          pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int unsigned ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned COUNT_W = ADDR_W + 1;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]    wr_ptr;
    logic [ADDR_W-1:0]    rd_ptr;
    logic                 push_ok;
    logic                 pop_ok;

    // A full buffer still accepts a push when the head leaves the same cycle.
    assign empty    = (count == '0);
    assign full     = (count == COUNT_W'(FIFO_DEPTH));
    assign pop_ok   = pop & ~empty;
    assign push_ok  = push & (~full | pop_ok);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage array, written only on accepted pushes.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + COUNT_W'(1);
                2'b01:   count <= count - COUNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_line_receiver.sv
// 8N1 UART receiver with mid-bit sampling, glitch rejection and a byte FIFO.
module uart_line_receiver
    import uart_line_receiver_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 50000000,
    parameter int unsigned UART_BAUD_RATE  = 9600,
    parameter int unsigned FIFO_DEPTH      = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_error,
    output logic                 overrun
);

    localparam int unsigned CYCLES_PER_BIT = cycles_per_bit(CLOCK_FREQUENCY, UART_BAUD_RATE);
    localparam int unsigned HALF_BIT       = half_bit(CLOCK_FREQUENCY, UART_BAUD_RATE);
    localparam int unsigned TIMER_W        = $clog2(CYCLES_PER_BIT) + 1;
    localparam logic [TIMER_W-1:0] BIT_RELOAD  = TIMER_W'(CYCLES_PER_BIT - 1);
    localparam logic [TIMER_W-1:0] HALF_RELOAD = TIMER_W'(HALF_BIT - 1);

    logic                 rx_meta;
    logic                 rx_s;
    logic [1:0]           state_q,      state_d;
    logic [TIMER_W-1:0]   timer_q,      timer_d;
    logic [2:0]           bit_idx_q,    bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,      shift_d;
    logic                 break_wait_q, break_wait_d;
    logic                 frame_error_d;
    logic                 push_c;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                 fifo_count_unused;

    assign fifo_count_unused = ^fifo_count;
    assign rx_valid          = ~fifo_empty;

    // Two-flop synchronizer for the asynchronous line, idling high.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    // Receiver state and registered error pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            break_wait_q <= 1'b0;
            frame_error  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            break_wait_q <= break_wait_d;
            frame_error  <= frame_error_d;
            overrun      <= push_c & fifo_full & ~(rx_ready & rx_valid);
        end
    end

    // Next-state logic; after a bad stop bit, wait for the line to go high before re-arming.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        break_wait_d  = break_wait_q & ~rx_s;
        frame_error_d = 1'b0;
        push_c        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!rx_s && !break_wait_q) begin
                    state_d = ST_START;
                    timer_d = HALF_RELOAD;
                end
            end
            ST_START: begin
                if (timer_q == '0) begin
                    if (!rx_s) begin
                        state_d   = ST_DATA;
                        timer_d   = BIT_RELOAD;
                        bit_idx_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            ST_DATA: begin
                if (timer_q == '0) begin
                    shift_d[bit_idx_q] = rx_s;
                    timer_d            = BIT_RELOAD;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            ST_STOP: begin
                if (timer_q == '0) begin
                    state_d = ST_IDLE;
                    if (rx_s) begin
                        push_c = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                        break_wait_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Received-byte buffer.
    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_c),
        .push_data (shift_q),
        .pop       (rx_ready),
        .pop_data  (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_uart_line_receiver.sv
// Self-checking bench for uart_line_receiver at 10 clocks per bit, 4-entry FIFO.
module tb_uart_line_receiver;

    localparam int unsigned CLK_FREQ = 1000000;
    localparam int unsigned BAUD     = 100000;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned CPB      = 10;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic       uart_rx  = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_error;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_cycles = 0, fe_pulses = 0, ov_cycles = 0, ov_pulses = 0;
    logic fe_prev = 1'b0, ov_prev = 1'b0;
    logic [7:0] exp_q [$];

    always #5 clock = ~clock;

    uart_line_receiver #(
        .CLOCK_FREQUENCY (CLK_FREQ),
        .UART_BAUD_RATE  (BAUD),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .uart_rx     (uart_rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_error (frame_error),
        .overrun     (overrun)
    );

    // Pulse monitor: counts high cycles and rising edges of the two error outputs.
    always @(negedge clock) begin
        if (frame_error === 1'b1) fe_cycles <= fe_cycles + 1;
        if (frame_error === 1'b1 && !fe_prev) fe_pulses <= fe_pulses + 1;
        if (overrun === 1'b1) ov_cycles <= ov_cycles + 1;
        if (overrun === 1'b1 && !ov_prev) ov_pulses <= ov_pulses + 1;
        fe_prev <= (frame_error === 1'b1);
        ov_prev <= (overrun === 1'b1);
    end

    // Drive one 8N1 frame; optionally raise rx_ready for the single stop-sample cycle.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic pop_at_stop,
                             output logic [7:0] head_seen, output logic v_before,
                             output logic v_after);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < int'(CPB); c++) begin
                @(negedge clock);
                if (c == 0) uart_rx = frame[i];
                if (i == 9 && c == 7) begin
                    head_seen = rx_data;
                    v_before  = rx_valid;
                    rx_ready  = pop_at_stop;
                end
                if (i == 9 && c == 8) begin
                    v_after  = rx_valid;
                    rx_ready = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        n_checks++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_frame_error: got %b expected 0", frame_error); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        reset = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_rx_valid: got %b expected 0", rx_valid); end
    endtask

    task automatic test_basic();
        logic [7:0] head, exp;
        logic vb, va;
        int fe0;
        fe0 = fe_pulses;
        rx_ready = 1'b1;
        repeat (5) @(negedge clock);
        rx_ready = 1'b0;
        @(negedge clock);
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ready_when_empty: rx_valid got %b expected 0", rx_valid); end
        exp_q.push_back(8'h48);
        send_byte(8'h48, 1'b1, 1'b0, head, vb, va);
        n_checks++; if (vb !== 1'b0) begin n_fail++; $display("FAIL basic_valid_early: got %b expected 0", vb); end
        n_checks++; if (va !== 1'b1) begin n_fail++; $display("FAIL basic_valid_latency: got %b expected 1", va); end
        repeat (10) @(negedge clock);
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_hold: got %b expected 1", rx_valid); end
        exp = exp_q.pop_front();
        n_checks++; if (rx_data !== exp) begin n_fail++; $display("FAIL basic_data: got %h expected %h", rx_data, exp); end
        rx_ready = 1'b1;
        @(negedge clock);
        rx_ready = 1'b0;
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop: rx_valid got %b expected 0", rx_valid); end
        n_checks++; if (fe_pulses != fe0) begin n_fail++; $display("FAIL basic_no_frame_error: pulses got %0d expected %0d", fe_pulses, fe0); end
    endtask

    task automatic test_glitch();
        logic [7:0] head, exp;
        logic vb, va;
        int fe0, ov0;
        fe0 = fe_pulses; ov0 = ov_pulses;
        @(negedge clock); uart_rx = 1'b0;
        repeat (3) @(negedge clock);
        uart_rx = 1'b1;
        repeat (30) @(negedge clock);
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %b expected 0", rx_valid); end
        n_checks++; if (fe_pulses != fe0 || ov_pulses != ov0) begin n_fail++; $display("FAIL glitch_pulses: fe %0d ov %0d expected %0d %0d", fe_pulses, ov_pulses, fe0, ov0); end
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1, 1'b0, head, vb, va);
        n_checks++; if (va !== 1'b1) begin n_fail++; $display("FAIL glitch_recover_valid: got %b expected 1", va); end
        exp = exp_q.pop_front();
        n_checks++; if (rx_data !== exp) begin n_fail++; $display("FAIL glitch_recover_data: got %h expected %h", rx_data, exp); end
        rx_ready = 1'b1; @(negedge clock); rx_ready = 1'b0;
    endtask

    task automatic test_frame_error();
        logic [7:0] head;
        logic vb, va;
        int fe0, fc0, ov0;
        fe0 = fe_pulses; fc0 = fe_cycles; ov0 = ov_pulses;
        send_byte(8'hA5, 1'b0, 1'b0, head, vb, va);
        n_checks++; if (va !== 1'b0) begin n_fail++; $display("FAIL ferr_no_push: rx_valid got %b expected 0", va); end
        repeat (15) @(negedge clock);
        uart_rx = 1'b1;
        repeat (150) @(negedge clock);
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ferr_fifo_empty: rx_valid got %b expected 0", rx_valid); end
        n_checks++; if (fe_pulses - fe0 != 1) begin n_fail++; $display("FAIL ferr_pulse_count: got %0d expected 1", fe_pulses - fe0); end
        n_checks++; if (fe_cycles - fc0 != 1) begin n_fail++; $display("FAIL ferr_pulse_width: got %0d expected 1", fe_cycles - fc0); end
        n_checks++; if (ov_pulses != ov0) begin n_fail++; $display("FAIL ferr_no_overrun: got %0d expected %0d", ov_pulses, ov0); end
    endtask

    task automatic test_overrun();
        logic [7:0] head, exp;
        logic vb, va;
        int ov0, oc0, t;
        ov0 = ov_pulses; oc0 = ov_cycles;
        for (int i = 1; i <= 5; i++) begin
            if (i <= int'(DEPTH)) exp_q.push_back(8'(i));
            send_byte(8'(i), 1'b1, 1'b0, head, vb, va);
            if (i == 4) begin
                n_checks++; if (ov_pulses != ov0) begin n_fail++; $display("FAIL ovr_early: got %0d expected %0d", ov_pulses, ov0); end
            end
        end
        repeat (2) @(negedge clock);
        n_checks++; if (ov_pulses - ov0 != 1) begin n_fail++; $display("FAIL ovr_pulse_count: got %0d expected 1", ov_pulses - ov0); end
        n_checks++; if (ov_cycles - oc0 != 1) begin n_fail++; $display("FAIL ovr_pulse_width: got %0d expected 1", ov_cycles - oc0); end
        while (exp_q.size() > 0) begin
            t = 0;
            while (rx_valid !== 1'b1 && t < 200) begin @(negedge clock); t++; end
            exp = exp_q.pop_front();
            n_checks++; if (rx_valid !== 1'b1 || rx_data !== exp) begin n_fail++; $display("FAIL ovr_pop_data: valid %b data %h expected %h", rx_valid, rx_data, exp); end
            rx_ready = 1'b1; @(negedge clock); rx_ready = 1'b0;
        end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drained: rx_valid got %b expected 0", rx_valid); end
    endtask

    task automatic test_full_pop();
        logic [7:0] head, exp;
        logic vb, va;
        int ov0, t;
        ov0 = ov_pulses;
        for (int i = 0; i < int'(DEPTH); i++) begin
            exp_q.push_back(8'h11 + 8'(i));
            send_byte(8'h11 + 8'(i), 1'b1, 1'b0, head, vb, va);
        end
        send_byte(8'h06, 1'b1, 1'b1, head, vb, va);
        exp = exp_q.pop_front();
        exp_q.push_back(8'h06);
        n_checks++; if (vb !== 1'b1 || head !== exp) begin n_fail++; $display("FAIL full_pop_head: valid %b data %h expected %h", vb, head, exp); end
        n_checks++; if (va !== 1'b1) begin n_fail++; $display("FAIL full_pop_valid: got %b expected 1", va); end
        repeat (2) @(negedge clock);
        n_checks++; if (ov_pulses != ov0) begin n_fail++; $display("FAIL full_pop_no_overrun: got %0d expected %0d", ov_pulses, ov0); end
        while (exp_q.size() > 0) begin
            t = 0;
            while (rx_valid !== 1'b1 && t < 200) begin @(negedge clock); t++; end
            exp = exp_q.pop_front();
            n_checks++; if (rx_valid !== 1'b1 || rx_data !== exp) begin n_fail++; $display("FAIL wrap_pop_data: valid %b data %h expected %h", rx_valid, rx_data, exp); end
            rx_ready = 1'b1; @(negedge clock); rx_ready = 1'b0;
        end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_drained: rx_valid got %b expected 0", rx_valid); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] head, exp;
        logic [9:0] frame;
        logic vb, va;
        int fe0, ov0;
        fe0 = fe_pulses; ov0 = ov_pulses;
        frame = {1'b1, 8'h3C, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clock); uart_rx = frame[i];
            repeat (CPB - 1) @(negedge clock);
        end
        @(negedge clock); reset = 1'b1; uart_rx = 1'b1;
        @(negedge clock); reset = 1'b0;
        repeat (150) @(negedge clock);
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_no_push: rx_valid got %b expected 0", rx_valid); end
        n_checks++; if (fe_pulses != fe0 || ov_pulses != ov0) begin n_fail++; $display("FAIL midreset_pulses: fe %0d ov %0d expected %0d %0d", fe_pulses, ov_pulses, fe0, ov0); end
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1, 1'b0, head, vb, va);
        exp = exp_q.pop_front();
        n_checks++; if (va !== 1'b1 || rx_data !== exp) begin n_fail++; $display("FAIL midreset_next_frame: valid %b data %h expected %h", va, rx_data, exp); end
        rx_ready = 1'b1; @(negedge clock); rx_ready = 1'b0;
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_pop: rx_valid got %b expected 0", rx_valid); end
    endtask

    // Runaway guard.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_full_pop();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_line_receiver.md
UART_LINE_RECEIVER -- requirements
Module: uart_line_receiver

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 50000000, clock rate in Hz.
REQ-002 SHALL have parameter UART_BAUD_RATE, default 9600, line bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, receive buffer entries (power of two, >=2).
REQ-004 SHALL have port clock  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port uart_rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 SHALL have port rx_data  output  8  head-of-FIFO byte, valid while rx_valid=1.
REQ-008 SHALL have port rx_valid  output  1  FIFO non-empty.
REQ-009 SHALL have port rx_ready  input  1  consumer accepts rx_data when rx_valid&rx_ready.
REQ-010 SHALL have port frame_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse: completed byte dropped, FIFO full.

Function
REQ-012 SHALL define CYCLES_PER_BIT = CLOCK_FREQUENCY / UART_BAUD_RATE (integer truncation) and HALF_BIT = CYCLES_PER_BIT/2.
REQ-013 SHALL pass uart_rx through a two-flop synchronizer (both flops reset to 1); all decisions use the synchronized value rx_s.
REQ-014 SHALL implement states IDLE, START, DATA, STOP; bit-timer width = clog2(CYCLES_PER_BIT)+1; bit index 3 bits.
REQ-015 IDLE: on rx_s=0 SHALL go to START with timer loaded to HALF_BIT-1.
REQ-016 START: at timer=0, SHALL go to DATA (timer=CYCLES_PER_BIT-1, index=0) if rx_s=0, else return to IDLE without output (glitch rejection).
REQ-017 DATA: at each timer=0 SHALL shift rx_s into bit [index] (LSB first), reload timer; after index 7, SHALL go to STOP with timer reloaded.
REQ-018 STOP: at timer=0 with rx_s=1 SHALL push the byte into the FIFO and go to IDLE; with rx_s=0 SHALL discard the byte, pulse frame_error for one cycle, and go to IDLE (a new start is detected only after rx_s returns high).
REQ-019 Push latency: rx_valid SHALL rise the cycle after the STOP sample cycle when the FIFO was empty.
REQ-020 FIFO pop SHALL occur on any cycle with rx_valid&rx_ready; rx_data SHALL advance to the next entry the following cycle.
REQ-021 Push when FIFO full and no pop the same cycle SHALL drop the byte and pulse overrun; push with simultaneous pop when full SHALL be accepted (count unchanged).
REQ-022 Push and pop on the same cycle when empty: the pop is not possible (rx_valid=0); the push SHALL be accepted.
REQ-023 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-024 rx_ready while rx_valid=0 SHALL have no effect.

Reset
REQ-025 reset SHALL force state IDLE, timer 0, index 0, FIFO empty, synchronizer flops to 1.
REQ-026 Reset values: rx_valid=0, rx_data=8'h00, frame_error=0, overrun=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; no push, no error pulse on the following cycles.

Structure
REQ-028 State encodings (IDLE/START/DATA/STOP) and the CYCLES_PER_BIT/HALF_BIT derivation SHALL live in the shared UART package, reused by the MCU UART.
REQ-029 The buffer SHALL be a separate sub-module uart_rx_fifo (parameter FIFO_DEPTH, width 8, push/pop/full/empty/count).

Verification (CLOCK_FREQUENCY=1000000, UART_BAUD_RATE=100000: 10 cycles/bit, FIFO_DEPTH=4)
REQ-030 Drive 8'h48 (8N1) with rx_ready=0 -> rx_valid=1, rx_data=8'h48, no error pulse; assert rx_ready one cycle -> rx_valid=0.
REQ-031 Low pulse of 3 cycles on idle line -> state returns to IDLE, rx_valid stays 0, no pulses.
REQ-032 Frame 8'hA5 with stop bit driven 0 -> frame_error pulses exactly one cycle, FIFO stays empty.
REQ-033 Five bytes 8'h01..8'h05 back-to-back with rx_ready=0 -> overrun pulses once on the fifth; popping yields 01,02,03,04 in order.
REQ-034 With FIFO full, hold rx_ready=1 while byte 8'h06 completes -> push accepted, no overrun, pop order continues correctly through pointer wrap.
REQ-035 Assert reset for one cycle during DATA of 8'h3C -> no byte, no pulses; a following 8'h3C frame is received intact.
